rtc_timekeeper: RTL
===================

// Module: rtc_timekeeper
// PURPOSE
// - Free-running hh:mm:ss time base that consumes the setting interface driven by the key/button control block.
// - Accepts stop_clk plus loaded hou/min/sec values; returns show_hou/show_min/show_sec for the display path.
// - Closes the loop: control reads show_* and edits them, then writes them back here.
// PARAMETERS
// - CLK_HZ     50_000_000  clk_50Mhz cycles per second tick; must be >= 2
// - HOUR_MOD   24          hour modulus, 12 or 24
// PORTS
// - clk_50Mhz   in   1  single system clock; all logic on its rising edge
// - rst_n       in   1  synchronous active-low reset, sampled on rising edge of clk_50Mhz
// - stop_clk    in   1  1 = hold time and prescaler; 0 = run
// - load        in   1  one-cycle strobe; capture set_hou/set_min/set_sec
// - set_hou     in   7  hour value to load, binary
// - set_min     in   7  minute value to load, binary
// - set_sec     in   7  second value to load, binary
// - show_hou    out  7  current hour, binary, 0..HOUR_MOD-1
// - show_min    out  7  current minute, binary, 0..59
// - show_sec    out  7  current second, binary, 0..59
// - sec_tick    out  1  one-cycle pulse on every second increment
// - load_err    out  1  one-cycle pulse when any loaded field was out of range
// - alarm       out  1  alarm flag; present only with RTC_ALARM_EN, otherwise tied 0
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): show_* = 0, prescaler = 0, sec_tick = 0, load_err = 0, alarm = 0. Reset wins over all other inputs.
// - Prescaler: counts 0..CLK_HZ-1 while stop_clk=0. At CLK_HZ-1 it wraps to 0 and asserts sec_tick on the next cycle, together with the show_* update.
// - stop_clk=1: prescaler and show_* frozen. Prescaler resumes from the held count when stop_clk returns to 0; it does not clear.
// - Increment chain, on a tick:
//   - sec 59 -> 0 and carries to min.
//   - min 59 -> 0 and carries to hou.
//   - hou HOUR_MOD-1 -> 0.
//   - All fields update in the same cycle. 23:59:59 -> 00:00:00 in one cycle.
// - Load, edge where load=1:
//   - show_* <= set_* in the following cycle; prescaler cleared to 0.
//   - Load takes priority over a coincident tick: the tick is discarded and sec_tick is not asserted.
//   - Load works regardless of stop_clk.
// - Range check on load:
//   - Any field >= its modulus (hou >= HOUR_MOD, min/sec >= 60) is loaded as 0; valid fields load normally.
//   - load_err pulses for exactly 1 cycle, coincident with the update.
// - Arithmetic: 7-bit unsigned. No field ever holds a value outside its range after reset or load.
// - Back-to-back load strobes: each is honoured; the last one wins.
// - sec_tick and load_err are registered, 1-cycle pulses; never held high.
// CONFIGURATION
// - RTC_ALARM_EN defined:
//   - Adds inputs alarm_hou[6:0], alarm_min[6:0] and alarm_on[0:0].
//   - alarm sets on the tick where the new time equals alarm_hou:alarm_min:00 while alarm_on=1.
//   - alarm stays high until alarm_on=0, load=1, or reset.
//   - No match is evaluated while stop_clk=1 or on load-written values.
// - RTC_ALARM_EN undefined: alarm ports absent except output alarm, which is driven constant 0. No alarm compare logic is present.
// TESTING
// - Use CLK_HZ=4 for all scenarios.
// - Reset: hold rst_n=0 for 3 cycles with load=1 -> show_*=0, sec_tick=0, load_err=0 after release.
// - Run: stop_clk=0 for 12 cycles -> sec_tick pulses on cycles 4, 8, 12; show_sec=3.
// - Wrap: load 23:59:59, run 4 cycles -> show=00:00:00 and one sec_tick; HOUR_MOD=12 variant: 11:59:59 -> 00:00:00.
// - Hold: stop_clk=1 at prescaler=2 for 20 cycles -> show_* and sec_tick unchanged; release -> tick after 2 cycles.
// - Bad load: set 25:61:07 -> show=00:00:07, load_err=1 for 1 cycle; load coincident with tick -> no sec_tick, loaded value kept.
// - Alarm (RTC_ALARM_EN): alarm 00:01, alarm_on=1, load 00:00:59, run 4 cycles -> alarm=1; alarm_on=0 -> alarm=0 next cycle.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss time base with a second prescaler, range-checked load, and a one-cycle tick pulse.
// Optional alarm compare is built when the RTC_ALARM_EN macro is defined.
module rtc_timekeeper #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic       clk_50Mhz,
    input  logic       rst_n,
    input  logic       stop_clk,
    input  logic       load,
    input  logic [6:0] set_hou,
    input  logic [6:0] set_min,
    input  logic [6:0] set_sec,
`ifdef RTC_ALARM_EN
    input  logic [6:0] alarm_hou,
    input  logic [6:0] alarm_min,
    input  logic       alarm_on,
`endif
    output logic [6:0] show_hou,
    output logic [6:0] show_min,
    output logic [6:0] show_sec,
    output logic       sec_tick,
    output logic       load_err,
    output logic       alarm
);

    localparam int unsigned FW = 7;
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [FW-1:0] MS_MOD  = FW'(60);
    localparam logic [FW-1:0] MS_MAX  = FW'(59);
    localparam logic [FW-1:0] HOU_LIM = FW'(HOUR_MOD);
    localparam logic [FW-1:0] HOU_MAX = FW'(HOUR_MOD - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [FW-1:0] hou_d;
    logic [FW-1:0] min_d;
    logic [FW-1:0] sec_d;
    logic          tick_d;
    logic          err_d;

    logic          hou_ok_c;
    logic          min_ok_c;
    logic          sec_ok_c;

    // Out-of-range fields are replaced by zero rather than clamped.
    always_comb begin
        hou_ok_c = (set_hou < HOU_LIM);
        min_ok_c = (set_min < MS_MOD);
        sec_ok_c = (set_sec < MS_MOD);
    end

    // Next-state: load beats a coincident tick; stop_clk freezes prescaler and time.
    always_comb begin
        presc_d = presc_q;
        hou_d   = show_hou;
        min_d   = show_min;
        sec_d   = show_sec;
        tick_d  = 1'b0;
        err_d   = 1'b0;

        if (load) begin
            presc_d = '0;
            hou_d   = hou_ok_c ? set_hou : '0;
            min_d   = min_ok_c ? set_min : '0;
            sec_d   = sec_ok_c ? set_sec : '0;
            err_d   = !(hou_ok_c && min_ok_c && sec_ok_c);
        end else if (!stop_clk) begin
            if (presc_q == PRE_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (show_sec == MS_MAX) begin
                    sec_d = '0;
                    if (show_min == MS_MAX) begin
                        min_d = '0;
                        hou_d = (show_hou == HOU_MAX) ? '0 : show_hou + FW'(1);
                    end else begin
                        min_d = show_min + FW'(1);
                    end
                end else begin
                    sec_d = show_sec + FW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            presc_q  <= '0;
            show_hou <= '0;
            show_min <= '0;
            show_sec <= '0;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            show_hou <= hou_d;
            show_min <= min_d;
            show_sec <= sec_d;
            sec_tick <= tick_d;
            load_err <= err_d;
        end
    end

`ifdef RTC_ALARM_EN
    logic alarm_d;

    // Match only on a real tick landing on hh:mm:00; loads never arm the alarm.
    always_comb begin
        alarm_d = alarm;
        if (load || !alarm_on) begin
            alarm_d = 1'b0;
        end else if (tick_d && (sec_d == '0) && (min_d == alarm_min) && (hou_d == alarm_hou)) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else begin
            alarm <= alarm_d;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule
